sodor5_verif_init_seq: RTL
==========================

Name: sodor5_verif_init_seq

Overview:
Sequences a sodor5 verification run as a single FSM. On `start` it writes pseudo-random values into the register-file write port and a fixed pattern into the dmem write port, holds the core in reset, then releases it. It then forwards generated instructions for a fixed number of cycles and raises `done`. It sits in sodor5_verif between the instruction generator and the shared core/model state.

Parameters:
NUM_REGS, 32, register-file entries to initialise.
WORD_SIZE, 32, data width of rf/dmem writes and instructions.
DMEM_WORDS, 16, dmem words to initialise (power of two).
RUN_CYCLES, 100, cycles the core runs after release.
SEED, 32'h0000028E, LFSR reset value; 0 is replaced by 1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a run
instr_gen  in  WORD_SIZE  instruction from the stimulus generator
rf_wen  out  1  register-file write enable
rf_waddr  out  5  register index
rf_wdata  out  WORD_SIZE  register data
dm_wen  out  1  dmem write enable
dm_waddr  out  $clog2(DMEM_WORDS)  dmem word index
dm_wdata  out  WORD_SIZE  dmem data
core_reset  out  1  reset to core and model
instr  out  WORD_SIZE  instruction to core and model
busy  out  1  high in INIT_RF, INIT_DM, DRAIN, RUN
done  out  1  sticky run-complete flag
cycle_count  out  32  RUN cycles elapsed

Behaviour:
- Clocking and reset: one clock `clk`; `reset` is synchronous and active-high.
- All outputs are registered. Reset values:
  - state=IDLE, rf_wen=dm_wen=0, addresses and data=0
  - core_reset=1, instr=32'h00000013 (NOP)
  - busy=0, done=0, cycle_count=0, lfsr=SEED
- A reset asserted mid-run aborts the run on the next edge to exactly these values.
- States: IDLE, INIT_RF, INIT_DM, DRAIN, RUN, DONE.
- IDLE:
  - start=1 -> INIT_RF, idx=0, done cleared.
  - First rf_wen appears the cycle after start is sampled.
- INIT_RF, one write per cycle for idx=0..NUM_REGS-1:
  - rf_wen=1, rf_waddr=idx, rf_wdata=lfsr (forced to 0 when idx==0).
  - lfsr advances every INIT_RF cycle, including idx 0.
  - After idx NUM_REGS-1 -> INIT_DM, idx=0.
- LFSR: Galois, next = (lfsr>>1) ^ (lfsr[0] ? 32'h80200003 : 0). It holds outside INIT_RF and is not reloaded by start.
- INIT_DM, one write per cycle for idx=0..DMEM_WORDS-1:
  - dm_wen=1, dm_waddr=idx, dm_wdata = idx[3:0] replicated 8 times (e.g. idx 5 -> 32'h55555555).
  - Then -> DRAIN.
- DRAIN: one cycle with both wen=0 and core_reset=1 -> RUN.
- RUN:
  - core_reset=0, instr <= instr_gen each cycle, so the first RUN cycle presents NOP.
  - cycle_count increments per RUN cycle.
  - When cycle_count reaches RUN_CYCLES -> DONE.
- DONE:
  - done=1, busy=0, instr=NOP, core_reset=1.
  - start=1 -> INIT_RF with cycle_count=0 and done=0.
- start is ignored in INIT_RF, INIT_DM, DRAIN and RUN.
- start and reset together: reset wins.
- Timing: start->core release = NUM_REGS+DMEM_WORDS+2 cycles (34+16=50 at defaults).
- Widths: idx is max($clog2(NUM_REGS),$clog2(DMEM_WORDS)) bits. cycle_count saturates at 2^32-1.

Decomposition:
- Package sodor5_verif_pkg:
  - state enum
  - NOP_INSTR=32'h00000013
  - LFSR_POLY=32'h80200003
  - NUM_REGS/WORD_SIZE defaults
- Sub-module sodor5_lfsr32: load, advance, and value ports, reused by the instruction generator.
- The FSM, counters and output registers stay in sodor5_verif_init_seq.

Test Plan:
- Reset held 3 cycles, then released with no start -> core_reset=1, instr=32'h13, busy=0, all wen=0 indefinitely.
- start at cycle t with SEED=0x28E -> the following rf writes are all required:
  - at t+1: rf_waddr=0, rf_wdata=0
  - at t+2: rf_waddr=1, rf_wdata=0x00000147
  - at t+3: rf_waddr=2, rf_wdata=0x802000A0
  - exactly 32 rf_wen cycles in total.
- Continuing the same run, the dmem and release timing are all required:
  - dm writes at t+33..t+48 with mem[5]=0x55555555 and mem[15]=0xFFFFFFFF
  - DRAIN at t+49, core_reset falls at t+50
  - the first instr at t+50 is NOP; instr at t+51 equals instr_gen sampled at t+50.
- RUN_CYCLES=100 -> done rises after exactly 100 RUN cycles with cycle_count=100, core_reset=1, instr=NOP. A second start reruns init with rf_wdata continuing from the prior lfsr value.
- reset pulsed during INIT_DM idx 7 -> next cycle every output is at its reset value; a later start restarts at rf idx 0 with lfsr=SEED.
- start pulsed during INIT_RF and again during RUN -> no effect: write counts and run length are unchanged and done rises on schedule.

Source files
------------

// File: rtl/sodor5_verif_pkg.sv
// Shared types and constants for the sodor5 verification sequencer and its helpers.
package sodor5_verif_pkg;

    localparam int          DEF_NUM_REGS  = 32;
    localparam int          DEF_WORD_SIZE = 32;
    localparam logic [31:0] NOP_INSTR     = 32'h00000013;
    localparam logic [31:0] LFSR_POLY     = 32'h80200003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_RF,
        ST_INIT_DM,
        ST_DRAIN,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/sodor5_lfsr32.sv
// 32-bit Galois LFSR with a load-to-seed control; shared with the instruction generator.
module sodor5_lfsr32
    import sodor5_verif_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000028E
) (
    input  logic        clk,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] value
);

    // An all-zero state would lock the register, so a zero seed becomes 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SEED_EFF;
        end else if (advance) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;

endmodule

// File: rtl/sodor5_verif_init_seq.sv
// Run sequencer: seeds the register file and dmem, holds the core in reset,
// releases it for a fixed number of cycles while forwarding instructions, then flags done.
module sodor5_verif_init_seq
    import sodor5_verif_pkg::*;
#(
    parameter int          NUM_REGS   = DEF_NUM_REGS,
    parameter int          WORD_SIZE  = DEF_WORD_SIZE,
    parameter int          DMEM_WORDS = 16,
    parameter int          RUN_CYCLES = 100,
    parameter logic [31:0] SEED       = 32'h0000028E
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WORD_SIZE-1:0]          instr_gen,
    output logic                          rf_wen,
    output logic [4:0]                    rf_waddr,
    output logic [WORD_SIZE-1:0]          rf_wdata,
    output logic                          dm_wen,
    output logic [$clog2(DMEM_WORDS)-1:0] dm_waddr,
    output logic [WORD_SIZE-1:0]          dm_wdata,
    output logic                          core_reset,
    output logic [WORD_SIZE-1:0]          instr,
    output logic                          busy,
    output logic                          done,
    output logic [31:0]                   cycle_count
);

    localparam int RF_AW = $clog2(NUM_REGS);
    localparam int DM_AW = $clog2(DMEM_WORDS);
    localparam int IDX_W = (RF_AW > DM_AW) ? RF_AW : DM_AW;
    localparam logic [WORD_SIZE-1:0] NOP_W = WORD_SIZE'(NOP_INSTR);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [32:0]            cnt_inc;

    logic                   rf_wen_q, rf_wen_d;
    logic [4:0]             rf_waddr_q, rf_waddr_d;
    logic [WORD_SIZE-1:0]   rf_wdata_q, rf_wdata_d;
    logic                   dm_wen_q, dm_wen_d;
    logic [DM_AW-1:0]       dm_waddr_q, dm_waddr_d;
    logic [WORD_SIZE-1:0]   dm_wdata_q, dm_wdata_d;
    logic                   core_reset_q, core_reset_d;
    logic [WORD_SIZE-1:0]   instr_q, instr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [31:0]            lfsr_value;

    // The LFSR steps on every edge that lands in INIT_RF, so its current value
    // is exactly the data owed to the write being registered on that edge.
    sodor5_lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .load    (reset),
        .advance (state_d == ST_INIT_RF),
        .value   (lfsr_value)
    );

    function automatic logic [WORD_SIZE-1:0] dm_pattern(input logic [3:0] nib);
        logic [WORD_SIZE-1:0] p;
        for (int i = 0; i < WORD_SIZE; i++) begin
            p[i] = nib[i % 4];
        end
        return p;
    endfunction

    assign cnt_inc = {1'b0, cnt_q} + 33'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            dm_wen_q     <= 1'b0;
            dm_waddr_q   <= '0;
            dm_wdata_q   <= '0;
            core_reset_q <= 1'b1;
            instr_q      <= NOP_W;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            dm_wen_q     <= dm_wen_d;
            dm_waddr_q   <= dm_waddr_d;
            dm_wdata_q   <= dm_wdata_d;
            core_reset_q <= core_reset_d;
            instr_q      <= instr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_INIT_RF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_INIT_RF: begin
                if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                    state_d = ST_INIT_DM;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_INIT_DM: begin
                if (idx_q == IDX_W'(DMEM_WORDS - 1)) begin
                    state_d = ST_DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_inc[32] ? 32'hFFFF_FFFF : cnt_inc[31:0];
                if (cnt_inc >= 33'(RUN_CYCLES)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the upcoming state so each write appears
    // in the very cycle its state is entered.
    always_comb begin
        rf_wen_d     = 1'b0;
        rf_waddr_d   = '0;
        rf_wdata_d   = '0;
        dm_wen_d     = 1'b0;
        dm_waddr_d   = '0;
        dm_wdata_d   = '0;
        core_reset_d = 1'b1;
        instr_d      = NOP_W;
        busy_d       = 1'b0;
        done_d       = (state_d == ST_DONE);
        unique case (state_d)
            ST_INIT_RF: begin
                rf_wen_d   = 1'b1;
                rf_waddr_d = 5'(idx_d);
                rf_wdata_d = (idx_d == '0) ? '0 : WORD_SIZE'(lfsr_value);
                busy_d     = 1'b1;
            end
            ST_INIT_DM: begin
                dm_wen_d   = 1'b1;
                dm_waddr_d = DM_AW'(idx_d);
                dm_wdata_d = dm_pattern(4'(idx_d));
                busy_d     = 1'b1;
            end
            ST_DRAIN: begin
                busy_d = 1'b1;
            end
            ST_RUN: begin
                core_reset_d = 1'b0;
                busy_d       = 1'b1;
                instr_d      = (state_q == ST_RUN) ? instr_gen : NOP_W;
            end
            default: begin
            end
        endcase
    end

    assign rf_wen      = rf_wen_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign dm_wen      = dm_wen_q;
    assign dm_waddr    = dm_waddr_q;
    assign dm_wdata    = dm_wdata_q;
    assign core_reset  = core_reset_q;
    assign instr       = instr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cycle_count = cnt_q;

endmodule
